// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared pixel type, constants and helpers for the ws2812 pixel arbiter
package ws2812_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    // Driver bit period in clocks; a full refill must fit inside one bit
    localparam int CYCLES_BIT = 63;

    // Width of a channel index; a single channel still gets one bit
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (component * (br + 1)) >> 8; br = 255 passes the component through
    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] br);
        logic [15:0] prod;
        prod = 16'(c) * (16'(br) + 16'd1);
        return prod[15:8];
    endfunction

    function automatic pixel_t scale_pixel(input pixel_t p, input logic [7:0] br);
        pixel_t s;
        s.r = scale8(p.r, br);
        s.g = scale8(p.g, br);
        s.b = scale8(p.b, br);
        return s;
    endfunction

endpackage

// File: rtl/ws2812_rr_arbiter.sv
// rtl/ws2812_rr_arbiter.sv - round-robin arbiter with a rotating priority pointer
module ws2812_rr_arbiter
    import ws2812_pkg::*;
#(
    parameter int N = 4,
    localparam int CHW = ch_width(N)
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic [N-1:0]   req_i,
    output logic [N-1:0]   grant_o,
    output logic [CHW-1:0] grant_idx_o,
    output logic           grant_valid_o
);

    logic [CHW-1:0] last_q;
    logic [CHW-1:0] last_d;

    // Search starts one past the previous winner so every requester is served within N grants
    always_comb begin
        int             c;
        logic [CHW-1:0] idx;
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        c             = 0;
        idx           = '0;
        for (int i = 0; i < N; i++) begin
            c = int'(last_q) + 1 + i;
            if (c >= N) begin
                c = c - N;
            end
            idx = CHW'(c);
            if (!grant_valid_o && req_i[idx]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = idx;
                grant_o[idx]  = 1'b1;
            end
        end
        last_d = grant_valid_o ? grant_idx_o : last_q;
    end

    // Pointer holds the last winner; reset value makes channel 0 win first
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_q <= CHW'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ws2812_pixel_arbiter.sv
// rtl/ws2812_pixel_arbiter.sv - shares one pixel RAM read port among ws2812 drivers; option WS2812_ARB_BRIGHTNESS_EN
module ws2812_pixel_arbiter
    import ws2812_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int ADDR_WIDTH  = 9,
    parameter int RAM_LATENCY = 1,
    localparam int CHW = ch_width(CHANNELS)
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] ch_address_i,
`ifdef WS2812_ARB_BRIGHTNESS_EN
    input  logic [7:0]                     brightness_i,
`endif
    output logic [CHANNELS*8-1:0]          ch_r_o,
    output logic [CHANNELS*8-1:0]          ch_g_o,
    output logic [CHANNELS*8-1:0]          ch_b_o,
    output logic [CHANNELS-1:0]            ch_valid_o,
    output logic                           ram_rd_o,
    output logic [CHW+ADDR_WIDTH-1:0]      ram_addr_o,
    input  logic [23:0]                    ram_data_i
);

    localparam int AW = ADDR_WIDTH;

    if (CHANNELS < 1 || CHANNELS > 16 || RAM_LATENCY < 1 || RAM_LATENCY > 3 ||
        CHANNELS + RAM_LATENCY + 1 >= CYCLES_BIT) begin : g_param_check
        $error("ws2812_pixel_arbiter: CHANNELS/RAM_LATENCY out of range or refill exceeds a bit period");
    end

    logic [AW-1:0]       addr       [CHANNELS];
    logic [AW-1:0]       req_addr_q [CHANNELS];
    logic [AW-1:0]       req_addr_d [CHANNELS];
    pixel_t              pixel_q    [CHANNELS];
    pixel_t              pixel_d    [CHANNELS];
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [CHANNELS-1:0] loaded_q, loaded_d;
    logic [CHANNELS-1:0] stale, eligible, gnt_onehot;
    logic                gnt_valid;
    logic [CHW-1:0]      gnt_idx;
    logic                ram_rd_q, ram_rd_d;
    logic [CHW+AW-1:0]   ram_addr_q, ram_addr_d;
    logic [RAM_LATENCY-1:0] pipe_v_q;
    logic [CHW-1:0]      pipe_ch_q  [RAM_LATENCY];
    logic                ret_valid;
    logic [CHW-1:0]      ret_ch;
    pixel_t              ret_pixel;

    // Unpack driver addresses, flag stale channels and present the held pixels
    always_comb begin
        addr       = '{default: '0};
        stale      = '0;
        eligible   = '0;
        ch_valid_o = '0;
        ch_r_o     = '0;
        ch_g_o     = '0;
        ch_b_o     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            addr[c]          = ch_address_i[c*AW +: AW];
            stale[c]         = !loaded_q[c] || (addr[c] != req_addr_q[c]);
            eligible[c]      = stale[c] && !pending_q[c];
            ch_valid_o[c]    = !stale[c] && !pending_q[c];
            ch_r_o[c*8 +: 8] = pixel_q[c].r;
            ch_g_o[c*8 +: 8] = pixel_q[c].g;
            ch_b_o[c*8 +: 8] = pixel_q[c].b;
        end
    end

    assign ret_valid = pipe_v_q[RAM_LATENCY-1];
    assign ret_ch    = pipe_ch_q[RAM_LATENCY-1];
`ifdef WS2812_ARB_BRIGHTNESS_EN
    assign ret_pixel = scale_pixel(pixel_t'(ram_data_i), brightness_i);
`else
    assign ret_pixel = pixel_t'(ram_data_i);
`endif

    ws2812_rr_arbiter #(
        .N (CHANNELS)
    ) u_arbiter (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .req_i         (eligible),
        .grant_o       (gnt_onehot),
        .grant_idx_o   (gnt_idx),
        .grant_valid_o (gnt_valid)
    );

    // Returning data lands first, then the new grant marks its channel as in flight
    always_comb begin
        req_addr_d = req_addr_q;
        pixel_d    = pixel_q;
        pending_d  = pending_q;
        loaded_d   = loaded_q;
        ram_rd_d   = gnt_valid;
        ram_addr_d = '0;
        if (ret_valid) begin
            pending_d[ret_ch] = 1'b0;
            loaded_d[ret_ch]  = 1'b1;
            pixel_d[ret_ch]   = ret_pixel;
        end
        if (gnt_valid) begin
            pending_d           = pending_d | gnt_onehot;
            req_addr_d[gnt_idx] = addr[gnt_idx];
            ram_addr_d          = {gnt_idx, addr[gnt_idx]};
        end
    end

    // Per-channel state and the registered RAM request
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_addr_q <= '{default: '0};
            pixel_q    <= '{default: '0};
            pending_q  <= '0;
            loaded_q   <= '0;
            ram_rd_q   <= 1'b0;
            ram_addr_q <= '0;
        end else begin
            req_addr_q <= req_addr_d;
            pixel_q    <= pixel_d;
            pending_q  <= pending_d;
            loaded_q   <= loaded_d;
            ram_rd_q   <= ram_rd_d;
            ram_addr_q <= ram_addr_d;
        end
    end

    // Return pipeline follows each issued read so it exits alongside its RAM data; reset drops reads in flight
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pipe_v_q  <= '0;
            pipe_ch_q <= '{default: '0};
        end else begin
            pipe_v_q[0]  <= ram_rd_q;
            pipe_ch_q[0] <= ram_addr_q[CHW+AW-1 -: CHW];
            for (int i = 1; i < RAM_LATENCY; i++) begin
                pipe_v_q[i]  <= pipe_v_q[i-1];
                pipe_ch_q[i] <= pipe_ch_q[i-1];
            end
        end
    end

    assign ram_rd_o   = ram_rd_q;
    assign ram_addr_o = ram_addr_q;

endmodule

// File: doc/ws2812_pixel_arbiter.md
# ws2812_pixel_arbiter

Shares one single-port pixel RAM read port among CHANNELS ws2812 strip drivers. Each driver presents a pixel address and expects stable r/g/b for it; this block detects address changes, schedules RAM reads round-robin, and holds a per-channel pixel register that feeds the driver's r/g/b inputs. It sits between the pixel RAM (host-written) and the bank of ws2812 serializers.

## Interface
- CHANNELS, 4: number of strip drivers served; 1..16
- ADDR_WIDTH, 9: per-channel pixel address width, matching the driver address_o
- RAM_LATENCY, 1: fixed cycles from ram_rd_o to ram_data_i valid; 1..3
- clk_i  in  1  system clock, 50 MHz
- rst_n_i  in  1  asynchronous, active-low reset
- ch_address_i  in  CHANNELS*ADDR_WIDTH  driver pixel addresses, channel c at slice c
- ch_r_o, ch_g_o, ch_b_o  out  CHANNELS*8 each  held pixel per channel
- ch_valid_o  out  CHANNELS  held pixel matches current channel address
- ram_rd_o  out  1  read strobe, one request per asserted cycle
- ram_addr_o  out  CHW+ADDR_WIDTH  {channel index, pixel address}, CHW = clog2(CHANNELS), min 1
- ram_data_i  in  24  {r[23:16], g[15:8], b[7:0]}, valid RAM_LATENCY cycles after ram_rd_o

## Operation
- Per channel c: req_addr[c] (address last issued), pending[c] (read in flight), loaded[c] (at least one read returned), pixel[c] (24 bits).
- stale[c] = !loaded[c] or (ch_address_i[c] != req_addr[c]); eligible[c] = stale[c] and !pending[c].
- Each cycle, if any channel is eligible: grant one by round-robin starting at last_grant+1 (mod CHANNELS); assert ram_rd_o, drive ram_addr_o = {c, ch_address_i[c]}, set req_addr[c], set pending[c]. At most one grant per cycle; reads pipeline back-to-back.
- Return pipeline: shift register of depth RAM_LATENCY carrying {valid, channel}. On valid exit: pixel[c] <= ram_data_i, pending[c] <= 0, loaded[c] <= 1.
- ch_valid_o[c] = loaded[c] and !pending[c] and ch_address_i[c] == req_addr[c].
- Address change while pending: returned data is still written (ch_valid_o stays 0); channel becomes eligible again the cycle after return.
- ch_r_o/g_o/b_o are registered; they change only on a return.

## Timing
- Reset: ram_rd_o=0, ram_addr_o=0, ch_valid_o=0, all pixel registers 0, pending=0, loaded=0, last_grant=CHANNELS-1 (channel 0 granted first). Return pipeline flushed; reads in flight at reset are discarded.
- Single stale channel: ram_rd_o in the cycle after the address change is registered (grant logic registered, 1 cycle), pixel and ch_valid_o updated RAM_LATENCY+1 cycles after ram_rd_o.
- Worst case refill (all channels change together): last channel valid within CHANNELS+RAM_LATENCY+1 cycles. Elaboration-time check: CHANNELS+RAM_LATENCY+1 < 63 (driver bit period); violations are an elaboration error.
- Channel index and address wrap via their natural widths; no other arithmetic.

## Configuration
- WS2812_ARB_BRIGHTNESS_EN defined: adds input brightness_i [7:0]; each component on return is stored as (component * (brightness_i + 1)) >> 8, 16-bit product truncated to 8 bits; brightness_i=255 is identity. Brightness is sampled at return, not retroactively applied.
- Undefined: no brightness_i port; ram_data_i stored unmodified.

## Structure
- Package ws2812_pkg: pixel_t struct {r, g, b}, CYCLES_BIT = 63, channel-index width function, brightness scale function.
- Sub-module ws2812_rr_arbiter: CHANNELS-wide request vector in, one-hot grant and index out, rotating priority pointer updated on grant.

## Test plan
- Reset then CHANNELS=4, all addresses 0, RAM word = 0x112233 -> four reads, channels 0,1,2,3 in order, all ch_valid_o=1 by cycle 6 after reset release, pixels 0x11/0x22/0x33.
- Channel 2 address 5->4 with others stable -> exactly one ram_rd_o, ram_addr_o={2,4}, ch_valid_o[2] low for RAM_LATENCY+2 cycles then high.
- Address change on channel 1 while its read pending -> stale data written, ch_valid_o[1]=0, second read issued the cycle after return, final pixel matches new address.
- All four channels change same cycle, RAM_LATENCY=3 -> four consecutive reads, none dropped, all valid within 8 cycles.
- rst_n_i asserted with two reads in flight -> outputs zero immediately; after release no stale return corrupts pixels.
- WS2812_ARB_BRIGHTNESS_EN, brightness_i=127, RAM word 0xFF8002 -> stored 0x7F4001.
